// File: rtl/bus_ep_pkg.sv
// rtl/bus_ep_pkg.sv - shared packet field helpers for the bus endpoint
// Purpose: packet layout constants and field extractors used by the
//          endpoint RTL and by its bench.
package bus_ep_pkg;

    localparam int ID_W  = 8;
    localparam int PKT_W = 16;

    // Destination ID lives in the top ID_W bits of a packet.
    function automatic logic [ID_W-1:0] dest_of(input logic [PKT_W-1:0] pkt);
        return pkt[PKT_W-1 -: ID_W];
    endfunction

    function automatic logic [PKT_W-ID_W-1:0] payload_of(input logic [PKT_W-1:0] pkt);
        return pkt[PKT_W-ID_W-1:0];
    endfunction

endpackage

// File: rtl/ep_sync_fifo.sv
// rtl/ep_sync_fifo.sv - first-word-fall-through synchronous FIFO
// Purpose: circular buffer with explicit occupancy count.
// Ports:  clk, reset (sync, active-high)
//         push_i/data_i   write side; ignored when full unless popping
//         pop_i           consume head; ignored when empty
//         full_o/empty_o/count_o occupancy status
//         head_o          current head, 0 when empty
module ep_sync_fifo #(
    parameter int width = 16,
    parameter int depth = 8,
    localparam int PTR_W = $clog2(depth),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [width-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o,
    output logic [width-1:0] head_o
);

    logic [width-1:0] mem_q [depth];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_ok, push_ok;

    // A pop frees a slot in the same cycle, so a full FIFO may accept a
    // simultaneous push.
    always_comb begin
        pop_ok   = pop_i && (count_q != '0);
        push_ok  = push_i && ((count_q != CNT_W'(depth)) || pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // depth is a power of two, so pointer overflow is the wrap
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push_ok && !pop_ok)      count_d = count_q + CNT_W'(1);
        else if (pop_ok && !push_ok) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_ok && !reset) mem_q[wr_ptr_q] <= data_i;
    end

    assign full_o  = (count_q == CNT_W'(depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/bus_endpoint_fifo.sv
// rtl/bus_endpoint_fifo.sv - per-device TX/RX packet endpoint for the bus arbiter
// Purpose: buffers device packets toward the bus (pndng/D_pop/pop) and bus
//          packets toward the device (push/D_push, rd_en/rd_data); tracks
//          dropped packets and misrouted arrivals.
// Ports:  clk, reset (sync, active-high)
//         wr_en/wr_data, tx_full, tx_count           device TX side
//         pndng, D_pop, pop                          bus TX side
//         push, D_push                               bus RX side
//         rd_en, rd_data, rx_empty, rx_count         device RX side
//         tx_ovf, rx_ovf, misroute, drop_cnt         sticky status
module bus_endpoint_fifo
    import bus_ep_pkg::*;
#(
    parameter int            pckg_sz   = 16,
    parameter int            depth     = 8,
    parameter logic [ID_W-1:0] dev_id    = 8'd0,
    parameter logic [ID_W-1:0] broadcast = 8'hFF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [pckg_sz-1:0]       wr_data,
    output logic                     tx_full,
    output logic [$clog2(depth):0]   tx_count,
    output logic                     pndng,
    output logic [pckg_sz-1:0]       D_pop,
    input  logic                     pop,
    input  logic                     push,
    input  logic [pckg_sz-1:0]       D_push,
    input  logic                     rd_en,
    output logic [pckg_sz-1:0]       rd_data,
    output logic                     rx_empty,
    output logic [$clog2(depth):0]   rx_count,
    output logic                     tx_ovf,
    output logic                     rx_ovf,
    output logic                     misroute,
    output logic [15:0]              drop_cnt
);

    logic        tx_empty, rx_full;
    logic        tx_drop, rx_drop, rx_accept, bad_dest;
    logic [ID_W-1:0] rx_dest;
    logic        tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d, misroute_q, misroute_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [16:0] drop_sum;

    ep_sync_fifo #(.width(pckg_sz), .depth(depth)) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (wr_en),
        .data_i  (wr_data),
        .pop_i   (pop),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .count_o (tx_count),
        .head_o  (D_pop)
    );

    ep_sync_fifo #(.width(pckg_sz), .depth(depth)) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .data_i  (D_push),
        .pop_i   (rd_en),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .count_o (rx_count),
        .head_o  (rd_data)
    );

    assign pndng = !tx_empty;

    // A full FIFO is never empty, so a same-cycle pop/read always frees a slot.
    assign tx_drop   = wr_en && tx_full && !pop;
    assign rx_drop   = push && rx_full && !rd_en;
    assign rx_accept = push && !rx_drop;
    assign rx_dest   = D_push[pckg_sz-1 -: ID_W];
    assign bad_dest  = (rx_dest != dev_id) && (rx_dest != broadcast);

    always_comb begin
        tx_ovf_d   = tx_ovf_q || tx_drop;
        rx_ovf_d   = rx_ovf_q || rx_drop;
        misroute_d = misroute_q || (rx_accept && bad_dest);
        // 17-bit sum so a double drop at FFFE still saturates cleanly
        drop_sum   = {1'b0, drop_cnt_q} + 17'(tx_drop) + 17'(rx_drop);
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_ovf_q   <= 1'b0;
            rx_ovf_q   <= 1'b0;
            misroute_q <= 1'b0;
            drop_cnt_q <= 16'h0000;
        end else begin
            tx_ovf_q   <= tx_ovf_d;
            rx_ovf_q   <= rx_ovf_d;
            misroute_q <= misroute_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign tx_ovf   = tx_ovf_q;
    assign rx_ovf   = rx_ovf_q;
    assign misroute = misroute_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_bus_endpoint_fifo.sv
// tb/tb_bus_endpoint_fifo.sv - self-checking bench for bus_endpoint_fifo
module tb_bus_endpoint_fifo;
    import bus_ep_pkg::*;

    localparam int          DEPTH = 8;
    localparam logic [7:0]  DEV   = 8'd2;

    logic        clk = 1'b0;
    logic        reset, wr_en, pop, push, rd_en;
    logic [15:0] wr_data, D_push;
    logic        tx_full, pndng, rx_empty, tx_ovf, rx_ovf, misroute;
    logic [3:0]  tx_count, rx_count;
    logic [15:0] D_pop, rd_data, drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] txq[$];
    logic [15:0] rxq[$];
    bit          m_txovf, m_rxovf, m_mis;
    int          m_drop;

    bus_endpoint_fifo #(.pckg_sz(16), .depth(DEPTH), .dev_id(DEV), .broadcast(8'hFF)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .tx_full(tx_full), .tx_count(tx_count), .pndng(pndng), .D_pop(D_pop),
        .pop(pop), .push(push), .D_push(D_push), .rd_en(rd_en),
        .rd_data(rd_data), .rx_empty(rx_empty), .rx_count(rx_count),
        .tx_ovf(tx_ovf), .rx_ovf(rx_ovf), .misroute(misroute), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour: queues with capacity DEPTH, pop applied before push
    // so a full queue with a valid pop has room for the new entry.
    task automatic model_edge();
        bit tpop, twr, tdrop, rpop, rwr, rdrop;
        if (reset) begin
            txq.delete(); rxq.delete();
            m_txovf = 0; m_rxovf = 0; m_mis = 0; m_drop = 0;
        end else begin
            tpop  = pop && (txq.size() > 0);
            twr   = wr_en && (txq.size() < DEPTH || tpop);
            tdrop = wr_en && !twr;
            rpop  = rd_en && (rxq.size() > 0);
            rwr   = push && (rxq.size() < DEPTH || rpop);
            rdrop = push && !rwr;
            if (tpop) void'(txq.pop_front());
            if (twr)  txq.push_back(wr_data);
            if (rpop) void'(rxq.pop_front());
            if (rwr) begin
                rxq.push_back(D_push);
                if (dest_of(D_push) != DEV && dest_of(D_push) != 8'hFF) m_mis = 1;
            end
            if (tdrop) m_txovf = 1;
            if (rdrop) m_rxovf = 1;
            m_drop = m_drop + int'(tdrop) + int'(rdrop);
            if (m_drop > 65535) m_drop = 65535;
        end
    endtask

    task automatic compare_all();
        chk("pndng",    pndng,    txq.size() != 0);
        chk("D_pop",    D_pop,    txq.size() != 0 ? txq[0] : 16'h0);
        chk("tx_count", tx_count, txq.size());
        chk("tx_full",  tx_full,  txq.size() == DEPTH);
        chk("rx_empty", rx_empty, rxq.size() == 0);
        chk("rd_data",  rd_data,  rxq.size() != 0 ? rxq[0] : 16'h0);
        chk("rx_count", rx_count, rxq.size());
        chk("tx_ovf",   tx_ovf,   m_txovf);
        chk("rx_ovf",   rx_ovf,   m_rxovf);
        chk("misroute", misroute, m_mis);
        chk("drop_cnt", drop_cnt, m_drop);
    endtask

    task automatic step(input logic w, input logic [15:0] wd, input logic p,
                        input logic ps, input logic [15:0] dp, input logic rd,
                        input logic rs);
        wr_en = w; wr_data = wd; pop = p; push = ps; D_push = dp; rd_en = rd; reset = rs;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle();
        step(0, 16'h0, 0, 0, 16'h0, 0, 0);
    endtask

    initial begin
        reset = 1; wr_en = 0; pop = 0; push = 0; rd_en = 0; wr_data = 0; D_push = 0;
        m_txovf = 0; m_rxovf = 0; m_mis = 0; m_drop = 0;
        step(0, 16'h0, 0, 0, 16'h0, 0, 1);
        step(0, 16'h0, 0, 0, 16'h0, 0, 1);
        chk("rst_pndng", pndng, 0);
        chk("rst_rx_empty", rx_empty, 1);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_D_pop", D_pop, 0);

        // TX ordering with one-cycle visibility
        step(1, 16'h0308, 0, 0, 16'h0, 0, 0);
        chk("tx_first_pndng", pndng, 1);
        step(1, 16'h0409, 0, 0, 16'h0, 0, 0);
        step(1, 16'h050A, 0, 0, 16'h0, 0, 0);
        chk("tx3_head", D_pop, 16'h0308);
        chk("tx3_count", tx_count, 3);
        step(0, 16'h0, 1, 0, 16'h0, 0, 0);
        chk("pop1_head", D_pop, 16'h0409);
        step(0, 16'h0, 1, 0, 16'h0, 0, 0);
        chk("pop2_head", D_pop, 16'h050A);
        step(0, 16'h0, 1, 0, 16'h0, 0, 0);
        chk("pop3_pndng", pndng, 0);
        // pop while empty with a write: pop ignored, write kept
        step(1, 16'h0777, 1, 0, 16'h0, 0, 0);
        chk("pop_empty_cnt", tx_count, 1);
        step(0, 16'h0, 1, 0, 16'h0, 0, 0);

        // TX overflow and write-while-full-with-pop
        for (int i = 0; i < 9; i++) begin
            step(1, 16'h0100 + 16'(i), 0, 0, 16'h0, 0, 0);
            if (i == 7) chk("tx_full_at8", tx_full, 1);
        end
        chk("tx_ovf_9th", tx_ovf, 1);
        chk("drop_9th", drop_cnt, 1);
        step(1, 16'hAAAA, 1, 0, 16'h0, 0, 0);
        chk("full_pop_cnt", tx_count, 8);
        chk("full_pop_head", D_pop, 16'h0101);
        chk("full_pop_drop", drop_cnt, 1);

        // RX route check
        step(0, 16'h0, 0, 1, 16'h0211, 0, 0);
        step(0, 16'h0, 0, 1, 16'hFF22, 0, 0);
        chk("rx2_count", rx_count, 2);
        chk("rx2_head", rd_data, 16'h0211);
        chk("rx2_mis", misroute, 0);
        step(0, 16'h0, 0, 1, 16'h0733, 0, 0);
        chk("rx3_mis", misroute, 1);
        chk("rx3_count", rx_count, 3);
        for (int i = 0; i < 5; i++) step(0, 16'h0, 0, 1, 16'h0240 + 16'(i), 0, 0);
        chk("rx_full_cnt", rx_count, 8);
        // simultaneous TX and RX drop adds two
        step(1, 16'hBBBB, 0, 1, 16'h0244, 0, 0);
        chk("dual_drop", drop_cnt, 3);
        chk("dual_rx_ovf", rx_ovf, 1);
        chk("dual_tx_ovf", tx_ovf, 1);
        // RX full with rd_en accepts the push
        step(0, 16'h0, 0, 1, 16'h0255, 1, 0);
        chk("rx_full_rd_drop", drop_cnt, 3);

        // mid-operation reset with 5 TX and 3 RX entries
        for (int i = 0; i < 3; i++) step(0, 16'h0, 1, 0, 16'h0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 16'h0, 0, 0, 16'h0, 1, 0);
        chk("pre_rst_tx", tx_count, 5);
        chk("pre_rst_rx", rx_count, 3);
        step(1, 16'h1234, 1, 1, 16'h0299, 1, 1);
        chk("mid_rst_pndng", pndng, 0);
        chk("mid_rst_rx_empty", rx_empty, 1);
        chk("mid_rst_txc", tx_count, 0);
        chk("mid_rst_rxc", rx_count, 0);
        chk("mid_rst_flags", {tx_ovf, rx_ovf, misroute}, 3'b000);
        chk("mid_rst_drop", drop_cnt, 0);
        idle();

        // wrap-around: write/pop pairs with random spacing
        for (int i = 0; i < 20; i++) begin
            step(1, 16'($urandom), 0, 0, 16'h0, 0, 0);
            repeat ($urandom_range(0, 3)) idle();
            step(0, 16'h0, 1, 0, 16'h0, 0, 0);
            chk("wrap_le_depth", tx_count <= DEPTH, 1);
        end

        // randomized traffic at varying load levels, occasional reset
        for (int seg = 0; seg < 6; seg++) begin
            for (int c = 0; c < 120; c++) begin
                step($urandom_range(0, 99) < 30 + seg * 10, 16'($urandom),
                     $urandom_range(0, 99) < 80 - seg * 10,
                     $urandom_range(0, 99) < 30 + seg * 10,
                     {($urandom_range(0, 3) == 0) ? 8'($urandom) : (($urandom_range(0, 1) == 1) ? DEV : 8'hFF), 8'($urandom)},
                     $urandom_range(0, 99) < 80 - seg * 10,
                     $urandom_range(0, 299) == 0);
                chk("rand_le_depth", (tx_count <= DEPTH) && (rx_count <= DEPTH), 1);
            end
        end

        // drop counter saturation
        step(0, 16'h0, 0, 0, 16'h0, 0, 1);
        for (int i = 0; i < DEPTH; i++) step(1, 16'h0300, 0, 1, 16'h0200, 0, 0);
        for (int i = 0; i < 32768; i++) step(1, 16'h0301, 0, 1, 16'h0201, 0, 0);
        chk("sat_drop", drop_cnt, 16'hFFFF);
        step(1, 16'h0302, 0, 1, 16'h0202, 0, 0);
        chk("sat_hold", drop_cnt, 16'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
